mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
// Shares the single-port unified program/data memory between three requesters:
// instruction fetch (IF), CPU load/store (DATA) and the debug/program loader (DBG).
// Sits between the control unit's fetch/memory stages and the memory macro.
// Serialises accesses with a req/ack handshake. Fixed priority DATA > IF > DBG,
// with a starvation override that guarantees DBG progress.
// PARAMETERS
// ADDR_W      8   memory address width
// DATA_W      16  memory data width (one instruction word)
// MEM_LAT     1   cycles from mem_en to valid mem_rdata; legal range 1..7
// STARVE_MAX  4   consecutive lost arbitrations after which DBG wins outright; range 1..15
// PORTS
// clk           in   1       system clock, rising edge
// reset_n       in   1       asynchronous, active-low reset
// if_req        in   1       fetch request; held until if_ack
// if_addr       in   ADDR_W  fetch address (read only)
// if_ack        out  1       one-cycle pulse: access done, rdata valid
// d_req         in   1       load/store request
// d_we          in   1       1=store, 0=load
// d_addr        in   ADDR_W  data address
// d_wdata       in   DATA_W  store data
// d_ack         out  1       one-cycle completion pulse
// dbg_req       in   1       debug request
// dbg_we        in   1       1=write, 0=read
// dbg_addr      in   ADDR_W  debug address
// dbg_wdata     in   DATA_W  debug write data
// dbg_ack       out  1       one-cycle completion pulse
// rdata         out  DATA_W  read data, registered, valid while any *_ack=1
// grant         out  3       one-hot owner {DBG,DATA,IF}, registered
// busy          out  1       1 in every state except IDLE
// mem_en        out  1       memory strobe, one cycle per access
// mem_we        out  1       memory write enable, qualified by mem_en
// mem_addr      out  ADDR_W  memory address
// mem_wdata     out  DATA_W  memory write data
// mem_rdata     in   DATA_W  memory read data, valid MEM_LAT cycles after mem_en
// BEHAVIOUR
// - Reset (async, immediate): state=IDLE; grant=0; all acks, mem_en, mem_we and busy = 0;
//   rdata=0; starve_cnt=0; latched addr/wdata=0. An access in flight is abandoned, no ack.
// - FSM IDLE -> ACCESS -> [WAIT] -> RESP -> IDLE:
//   IDLE:   if any req, pick a winner and latch its we/addr/wdata and the one-hot grant;
//           go to ACCESS. Otherwise stay.
//   ACCESS: mem_en=1 for exactly one cycle. mem_we, mem_addr and mem_wdata come from the latch.
//           Load lat_cnt=MEM_LAT-1. Go to RESP if MEM_LAT==1, else to WAIT.
//   WAIT:   decrement lat_cnt; go to RESP after the cycle in which lat_cnt==1.
//   RESP:   ack of the granted port =1 (Moore). rdata was captured from mem_rdata on the
//           RESP-entry edge, for reads only; writes leave rdata unchanged. Next state: IDLE; grant clears.
// - Latency: req sampled in IDLE cycle T -> mem_en at T+1 -> ack at T+1+MEM_LAT.
//   Minimum spacing between transactions is MEM_LAT+2 cycles.
// - Requester rule: drop req on the edge that ends its ack cycle. A req still high in IDLE
//   is treated as a new access.
// - Priority: DATA > IF > DBG. Exception: DBG wins when starve_cnt==STARVE_MAX.
// - starve_cnt increments (saturating) at each IDLE decision where DBG requests and loses.
//   It clears when DBG is granted, or when dbg_req=0 in IDLE.
// - mem_we, mem_addr and mem_wdata are 0 whenever mem_en=0.
// - Inputs are ignored outside IDLE. If a req drops mid-transaction, the access still completes
//   and its ack still pulses; the arbiter never aborts except on reset.
// - Simultaneous requests: exactly one grant per IDLE cycle; losers stay pending with no side effect.
// - Only one ack is high in any cycle. It is always the ack of the port set in grant.
// STRUCTURE
// - Shared package cpu_pkg: requester indices REQ_IF=0, REQ_DATA=1, REQ_DBG=2;
//   arbiter state encodings ARB_IDLE/ACCESS/WAIT/RESP (2 bits); ADDR_W/DATA_W defaults.
// - One sub-module, mem_arb_select: combinational priority/starvation pick.
//   Inputs: reqs[2:0], starve_hit. Output: one-hot winner.
// - Counters (lat_cnt 3b, starve_cnt 4b) and the FSM stay in this module.
// TESTING
// 1 Reset: pull reset_n low while in WAIT (MEM_LAT=3) -> mem_en=0, no ack, grant=0 at once;
//   after release a fresh if_req completes normally.
// 2 Single load: d_req, d_addr=8'h20, memory holds 16'hBEEF, MEM_LAT=1 -> mem_en at T+1,
//   d_ack and rdata=16'hBEEF at T+2.
// 3 Contention: if_req and d_req rise in the same cycle -> DATA is served first; if_ack follows
//   exactly MEM_LAT+2 cycles after d_ack.
// 4 Starvation: dbg_req held while DATA/IF requests alternate, STARVE_MAX=4 -> DBG loses 4 times,
//   wins the 5th arbitration despite d_req=1, and starve_cnt returns to 0.
// 5 Store: dbg_we=1, dbg_addr=8'h05, dbg_wdata=16'h1234 -> mem_we=1 only in the ACCESS cycle;
//   rdata unchanged; a subsequent if_addr=8'h05 read returns 16'h1234.
// 6 Latency sweep MEM_LAT=1..4 -> ack at T+1+MEM_LAT each time; no two acks in one cycle;
//   a held req re-arbitrates in the IDLE cycle after RESP.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the memory-port arbiter: requester indices, FSM encoding, default widths.
// No logic, no latency.
// No flow control of its own.
package cpu_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;

    localparam int NUM_REQ  = 3;
    localparam int REQ_IF   = 0;
    localparam int REQ_DATA = 1;
    localparam int REQ_DBG  = 2;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_WAIT   = 2'd2,
        ARB_RESP   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_arb_select.sv
// Priority pick among IF/DATA/DBG requests: DATA > IF > DBG, DBG outright when starved.
// Combinational, zero latency.
// No backpressure; the caller only samples the winner in its idle state.
module mem_arb_select
    import cpu_pkg::*;
(
    input  logic [NUM_REQ-1:0] reqs,
    input  logic               starve_hit,
    output logic [NUM_REQ-1:0] winner
);

    always_comb begin
        winner = '0;
        if (starve_hit && reqs[REQ_DBG]) begin
            winner[REQ_DBG] = 1'b1;
        end else if (reqs[REQ_DATA]) begin
            winner[REQ_DATA] = 1'b1;
        end else if (reqs[REQ_IF]) begin
            winner[REQ_IF] = 1'b1;
        end else if (reqs[REQ_DBG]) begin
            winner[REQ_DBG] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IF / DATA / DBG accesses onto one single-port memory with a req/ack handshake.
// Latency: req sampled in IDLE cycle T -> mem_en at T+1 -> ack at T+1+MEM_LAT.
// Backpressure: requesters hold req until their one-cycle ack; inputs ignored outside IDLE.
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] rdata,
    output logic [2:0]        grant,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [2:0] LAT_LOAD   = 3'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    arb_state_t          state_q, state_d;
    logic [2:0]          grant_q, grant_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [2:0]          lat_cnt_q, lat_cnt_d;
    logic [3:0]          starve_cnt_q, starve_cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [2:0]          ack_q, ack_d;
    logic                busy_q, busy_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

    logic [NUM_REQ-1:0]  reqs;
    logic [NUM_REQ-1:0]  winner;

    assign reqs = {dbg_req, d_req, if_req};

    mem_arb_select u_select (
        .reqs       (reqs),
        .starve_hit (starve_cnt_q == STARVE_LIM),
        .winner     (winner)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        lat_cnt_d    = lat_cnt_q;
        starve_cnt_d = starve_cnt_q;
        rdata_d      = rdata_q;
        ack_d        = '0;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;

        case (state_q)
            ARB_IDLE: begin
                // Starvation is only tracked while DBG is actually asking.
                if (!dbg_req || winner[REQ_DBG]) begin
                    starve_cnt_d = '0;
                end else if (starve_cnt_q != 4'hF) begin
                    starve_cnt_d = starve_cnt_q + 4'd1;
                end
                if (|reqs) begin
                    state_d = ARB_ACCESS;
                    grant_d = winner;
                    if (winner[REQ_DATA]) begin
                        we_d    = d_we;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                    end else if (winner[REQ_IF]) begin
                        we_d    = 1'b0;
                        addr_d  = if_addr;
                        wdata_d = '0;
                    end else begin
                        we_d    = dbg_we;
                        addr_d  = dbg_addr;
                        wdata_d = dbg_wdata;
                    end
                end
            end
            ARB_ACCESS: begin
                lat_cnt_d = LAT_LOAD;
                state_d   = (MEM_LAT == 1) ? ARB_RESP : ARB_WAIT;
            end
            ARB_WAIT: begin
                lat_cnt_d = lat_cnt_q - 3'd1;
                if (lat_cnt_q == 3'd1) begin
                    state_d = ARB_RESP;
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
            default: state_d = ARB_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the next state.
        if (state_d == ARB_ACCESS) begin
            mem_en_d    = 1'b1;
            mem_we_d    = we_d;
            mem_addr_d  = addr_d;
            mem_wdata_d = wdata_d;
        end
        if (state_d == ARB_RESP) begin
            ack_d = grant_q;
            if (!we_q) begin
                rdata_d = mem_rdata;
            end
        end
        busy_d = (state_d != ARB_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ARB_IDLE;
            grant_q      <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            lat_cnt_q    <= '0;
            starve_cnt_q <= '0;
            rdata_q      <= '0;
            ack_q        <= '0;
            busy_q       <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            rdata_q      <= rdata_d;
            ack_q        <= ack_d;
            busy_q       <= busy_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign if_ack    = ack_q[REQ_IF];
    assign d_ack     = ack_q[REQ_DATA];
    assign dbg_ack   = ack_q[REQ_DBG];
    assign rdata     = rdata_q;
    assign grant     = grant_q;
    assign busy      = busy_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
